// File: rtl/apb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_pkg : shared FSM state type and byte-strobe mask helper
// Rev 1.0
// ---------------------------------------------------------------------------
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } apb_state_e;

   // Widest supported bus is 32 bits; narrower banks slice the low bits.
   function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
      logic [31:0] mask;
      for (int b = 0; b < 4; b++) begin
         mask[8*b +: 8] = {8{strb[b]}};
      end
      return mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_reg_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_reg_bank : register storage array with byte-enable writes
// Rev 1.0
// ---------------------------------------------------------------------------
module apb_reg_bank
   import apb_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_we,
   input  logic [IDX_W-1:0]             i_idx,
   input  logic [DATA_W-1:0]            i_wdata,
   input  logic [DATA_W/8-1:0]          i_strb,
   output logic [NUM_REGS*DATA_W-1:0]   o_q
);

   logic [DATA_W-1:0] r_mem [NUM_REGS];
   logic [31:0]       w_mask_full;
   logic [DATA_W-1:0] w_mask;

   assign w_mask_full = strb_to_mask(4'(i_strb));
   assign w_mask      = w_mask_full[DATA_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_idx] <= (r_mem[i_idx] & ~w_mask) | (i_wdata & w_mask);
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign o_q[g*DATA_W +: DATA_W] = r_mem[g];
   end

endmodule
`default_nettype wire

// File: rtl/apb_regfile_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_regfile_slave : APB slave with wait states, decode and RO registers
// Rev 1.0
// ---------------------------------------------------------------------------
module apb_regfile_slave
   import apb_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                NUM_REGS    = 16,
   parameter logic [31:0]       BASE_ADDR   = 32'h7000_0000,
   parameter int                WAIT_STATES = 1,
   parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
   input  logic                         pclk,
   input  logic                         presetn,
   input  logic                         psel,
   input  logic                         penable,
   input  logic                         pwrite,
   input  logic [31:0]                  paddr,
   input  logic [DATA_W-1:0]            pwdata,
   input  logic [DATA_W/8-1:0]          pstrb,
   output logic [DATA_W-1:0]            prdata,
   output logic                         pready,
   output logic                         pslverr,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q,
   output logic [NUM_REGS-1:0]          wr_pulse,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_status
);

   localparam int          c_NB      = DATA_W / 8;
   localparam int          c_ALSB    = $clog2(c_NB);
   localparam int          c_IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [31:0] c_ALIGN   = 32'(c_NB - 1);
   localparam logic [2:0]  c_WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   apb_state_e              r_state, w_next;
   logic [2:0]              r_wcnt;
   logic                    r_pready;
   logic [31:0]             r_addr;
   logic                    r_write;
   logic [DATA_W-1:0]       r_wdata;
   logic [DATA_W/8-1:0]     r_strb;

   logic                    w_latch;
   logic [31:0]             w_offset;
   logic [31:0]             w_word;
   logic [c_IDX_W-1:0]      w_idx;
   logic                    w_dec_err;
   logic                    w_ro;
   logic                    w_err;
   logic                    w_in_resp;
   logic                    w_commit;
   logic [DATA_W-1:0]       w_rd;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (psel && !penable) w_next = ST_SETUP;
         ST_SETUP: begin
            if (!psel)        w_next = ST_IDLE;
            else if (penable) w_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            if (!psel)                    w_next = ST_IDLE;
            else if (r_wcnt == c_WS_LAST) w_next = ST_RESP;
         end
         default:  w_next = ST_IDLE;
      endcase
   end

   assign w_latch = (r_state == ST_SETUP) && psel && penable;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state  <= ST_IDLE;
         r_wcnt   <= '0;
         r_pready <= 1'b0;
         r_addr   <= '0;
         r_write  <= 1'b0;
         r_wdata  <= '0;
         r_strb   <= '0;
      end else begin
         r_state  <= w_next;
         r_pready <= (w_next == ST_RESP);
         if (r_state == ST_WAIT && w_next == ST_WAIT) r_wcnt <= r_wcnt + 3'd1;
         else                                         r_wcnt <= '0;
         if (w_latch) begin
            r_addr  <= paddr;
            r_write <= pwrite;
            r_wdata <= pwdata;
            r_strb  <= pstrb;
         end
      end
   end

   // Decode runs off the latched address so late bus changes cannot leak in.
   assign w_offset  = r_addr - BASE_ADDR;
   assign w_word    = w_offset >> c_ALSB;
   assign w_idx     = w_word[c_IDX_W-1:0];
   assign w_dec_err = (r_addr < BASE_ADDR) || ((w_offset & c_ALIGN) != '0) ||
                      (w_word >= 32'(NUM_REGS));
   assign w_ro      = !w_dec_err && RO_MASK[w_idx];
   assign w_err     = w_dec_err || (r_write && w_ro);
   assign w_in_resp = (r_state == ST_RESP);
   assign w_commit  = w_in_resp && r_write && !w_err;
   assign w_rd      = w_ro ? hw_status[w_idx*DATA_W +: DATA_W] : reg_q[w_idx*DATA_W +: DATA_W];

   assign pready  = r_pready;
   assign pslverr = w_in_resp && w_err;
   assign prdata  = (w_in_resp && !w_err) ? w_rd : '0;

   always_comb begin
      wr_pulse = '0;
      if (w_commit) wr_pulse[w_idx] = 1'b1;
   end

   apb_reg_bank #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .IDX_W    (c_IDX_W)
   ) u_bank (
      .clk     (pclk),
      .rst_n   (presetn),
      .i_we    (w_commit),
      .i_idx   (w_idx),
      .i_wdata (r_wdata),
      .i_strb  (r_strb),
      .o_q     (reg_q)
   );

endmodule
`default_nettype wire

// File: tb/tb_apb_regfile_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apb_regfile_slave : directed self-checking bench for apb_regfile_slave
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_apb_regfile_slave;

   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 16;

   logic                        pclk = 1'b0;
   logic                        presetn;
   logic                        psel, penable, pwrite;
   logic [31:0]                 paddr;
   logic [DATA_W-1:0]           pwdata;
   logic [DATA_W/8-1:0]         pstrb;
   logic [DATA_W-1:0]           prdata;
   logic                        pready, pslverr;
   logic [NUM_REGS*DATA_W-1:0]  reg_q;
   logic [NUM_REGS-1:0]         wr_pulse;
   logic [NUM_REGS*DATA_W-1:0]  hw_status;

   int                          n_chk  = 0;
   int                          n_fail = 0;
   logic [31:0]                 exp_regs [NUM_REGS];

   logic [31:0]                 rd;
   logic                        er;
   logic [15:0]                 pl;
   int                          ws;
   logic                        seen;

   always #5 pclk = ~pclk;

   apb_regfile_slave #(
      .DATA_W      (DATA_W),
      .NUM_REGS    (NUM_REGS),
      .BASE_ADDR   (32'h7000_0000),
      .WAIT_STATES (1),
      .RO_MASK     (16'h0004)
   ) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr),
      .reg_q     (reg_q),
      .wr_pulse  (wr_pulse),
      .hw_status (hw_status)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NUM_REGS; i++) begin
         chk($sformatf("%s reg_q[%0d]", tag, i), reg_q[i*32 +: 32], exp_regs[i]);
      end
   endtask

   // Bus is scrambled during wait cycles; the slave must use its latched copy.
   task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [31:0] rdata,
                           output logic err, output logic [15:0] pulse, output int waits);
      logic done;
      done  = 1'b0;
      waits = 0;
      rdata = '0;
      err   = 1'b0;
      pulse = '0;
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      @(posedge pclk); #1;
      penable = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(posedge pclk); #1;
         if (pready) begin
            done  = 1'b1;
            rdata = prdata;
            err   = pslverr;
            pulse = wr_pulse;
         end else begin
            waits++;
            pwdata = ~data; paddr = addr ^ 32'h4; pstrb = ~strb; pwrite = !wr;
         end
      end
      if (!done) chk("timeout pready", 32'd0, 32'd1);
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      chk("pready one cycle", {31'd0, pready}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      hw_status = '0;
      for (int i = 0; i < NUM_REGS; i++) hw_status[i*32 +: 32] = 32'hDEAD_0000 | 32'(i);
      hw_status[2*32 +: 32] = 32'h0000_0055;
      for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
      presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;

      repeat (3) @(posedge pclk);
      #1;
      chk("reset pready",   {31'd0, pready},  32'd0);
      chk("reset pslverr",  {31'd0, pslverr}, 32'd0);
      chk("reset prdata",   prdata,           32'd0);
      chk("reset wr_pulse", {16'd0, wr_pulse}, 32'd0);
      check_regs("reset");
      presetn = 1'b1;

      // write 6 to reg0, read back
      apb_xfer(32'h7000_0000, 1'b1, 32'd6, 4'hF, rd, er, pl, ws);
      chk("wr0 pslverr", {31'd0, er}, 32'd0);
      chk("wr0 waits",   32'(ws),     32'd1);
      chk("wr0 pulse",   {16'd0, pl}, 32'h0001);
      exp_regs[0] = 32'd6;
      apb_xfer(32'h7000_0000, 1'b0, 32'd0, 4'h0, rd, er, pl, ws);
      chk("rd0 prdata",  rd,          32'd6);
      chk("rd0 pslverr", {31'd0, er}, 32'd0);
      chk("rd0 waits",   32'(ws),     32'd1);
      chk("rd0 pulse",   {16'd0, pl}, 32'h0000);

      // misaligned write
      apb_xfer(32'h7000_0005, 1'b1, 32'h4C, 4'hF, rd, er, pl, ws);
      chk("misalign pslverr", {31'd0, er}, 32'd1);
      chk("misalign pulse",   {16'd0, pl}, 32'h0000);
      check_regs("misalign");

      // byte strobes on reg3
      apb_xfer(32'h7000_000C, 1'b1, 32'hAABB_CCDD, 4'hF, rd, er, pl, ws);
      chk("wr3 pulse", {16'd0, pl}, 32'h0008);
      apb_xfer(32'h7000_000C, 1'b1, 32'h1122_3344, 4'b0101, rd, er, pl, ws);
      chk("wr3 strb pslverr", {31'd0, er}, 32'd0);
      exp_regs[3] = 32'hAA22_CC44;
      apb_xfer(32'h7000_000C, 1'b0, 32'd0, 4'h0, rd, er, pl, ws);
      chk("rd3 prdata", rd, 32'hAA22_CC44);

      // read-only register 2
      apb_xfer(32'h7000_0008, 1'b1, 32'h99, 4'hF, rd, er, pl, ws);
      chk("ro wr pslverr", {31'd0, er}, 32'd1);
      chk("ro wr pulse",   {16'd0, pl}, 32'h0000);
      apb_xfer(32'h7000_0008, 1'b0, 32'd0, 4'h0, rd, er, pl, ws);
      chk("ro rd prdata",  rd,          32'h55);
      chk("ro rd pslverr", {31'd0, er}, 32'd0);

      // out of range above and below
      apb_xfer(32'h7000_0040, 1'b0, 32'd0, 4'h0, rd, er, pl, ws);
      chk("oor rd pslverr", {31'd0, er}, 32'd1);
      chk("oor rd prdata",  rd,          32'd0);
      apb_xfer(32'h6FFF_FFFC, 1'b0, 32'd0, 4'h0, rd, er, pl, ws);
      chk("below rd pslverr", {31'd0, er}, 32'd1);
      chk("below rd prdata",  rd,          32'd0);

      // zero-strobe write still pulses but changes nothing
      apb_xfer(32'h7000_0010, 1'b1, 32'hFFFF_FFFF, 4'h0, rd, er, pl, ws);
      chk("strb0 pulse",   {16'd0, pl}, 32'h0010);
      chk("strb0 pslverr", {31'd0, er}, 32'd0);
      apb_xfer(32'h7000_0010, 1'b0, 32'd0, 4'h0, rd, er, pl, ws);
      chk("strb0 rd prdata", rd, 32'd0);

      // psel dropped in SETUP: transfer abandoned
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h7000_0004;
      pwdata = 32'h77; pstrb = 4'hF;
      @(posedge pclk); #1;
      psel = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge pclk); #1;
         seen = seen | pready | (wr_pulse != '0);
      end
      chk("abort activity", {31'd0, seen}, 32'd0);
      check_regs("abort");

      // reset during WAIT of a write
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h7000_0014;
      pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      presetn = 1'b0;
      #1;
      chk("rst mid pready",   {31'd0, pready},   32'd0);
      chk("rst mid pslverr",  {31'd0, pslverr},  32'd0);
      chk("rst mid wr_pulse", {16'd0, wr_pulse}, 32'd0);
      psel = 1'b0; penable = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
      @(posedge pclk); #1;
      check_regs("rst mid");
      presetn = 1'b1;
      apb_xfer(32'h7000_0014, 1'b1, 32'h1234_5678, 4'hF, rd, er, pl, ws);
      chk("post rst wr pulse", {16'd0, pl}, 32'h0020);
      chk("post rst wr waits", 32'(ws),     32'd1);
      exp_regs[5] = 32'h1234_5678;
      apb_xfer(32'h7000_0014, 1'b0, 32'd0, 4'h0, rd, er, pl, ws);
      chk("post rst rd prdata", rd, 32'h1234_5678);
      check_regs("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/apb_regfile_slave.md
APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, APB data width and register width; legal values 8, 16, 32.
REQ-002 SHALL have parameter NUM_REGS, default 16, number of registers; legal range 1..256.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h7000_0000, byte address of register 0.
REQ-004 SHALL have parameter WAIT_STATES, default 1, number of pready-low ACCESS cycles; legal range 0..7.
REQ-005 SHALL have parameter RO_MASK, default all zeros, NUM_REGS bits; bit i set means register i is read-only.
REQ-006 SHALL use one clock, and reset SHALL be asynchronous and active-low: pclk  in  1  clock; presetn  in  1  async active-low reset.
REQ-007 SHALL have ports: psel  in  1  select; penable  in  1  access phase; pwrite  in  1  1=write.
REQ-008 SHALL have ports: paddr  in  32  byte address; pwdata  in  DATA_W  write data; pstrb  in  DATA_W/8  byte strobes.
REQ-009 SHALL have ports: prdata  out  DATA_W  read data; pready  out  1  transfer done; pslverr  out  1  error.
REQ-010 SHALL have ports: reg_q  out  NUM_REGS*DATA_W  flattened register contents; wr_pulse  out  NUM_REGS  one-cycle write strobe per register.
REQ-011 SHALL have port hw_status  in  NUM_REGS*DATA_W  values returned on reads of read-only registers.

Function
REQ-012 SHALL be word-addressed: offset = paddr - BASE_ADDR; index = offset >> log2(DATA_W/8).
REQ-013 SHALL decode each transfer as error if paddr < BASE_ADDR, index >= NUM_REGS, or offset is not aligned to DATA_W/8.
REQ-014 SHALL run FSM IDLE -> SETUP on psel&!penable; SETUP -> WAIT on psel&penable.
REQ-015 SHALL stay in WAIT for exactly WAIT_STATES cycles, then go to RESP; with WAIT_STATES=0 it SHALL go SETUP -> RESP directly.
REQ-016 SHALL assert pready high for exactly one cycle in RESP, registered, then return to IDLE with pready low.
REQ-017 SHALL drop to IDLE without completing when psel is deasserted in SETUP or WAIT: no register update, no pready.
REQ-018 SHALL latch paddr, pwrite, pwdata and pstrb at the SETUP->ACCESS edge; later bus changes SHALL be ignored until the transfer completes.
REQ-019 SHALL commit a legal write to a writable register in the RESP cycle, updating only bytes with pstrb set.
REQ-020 SHALL pulse wr_pulse[index] for one cycle concurrently with the commit, even when pstrb is all zeros.
REQ-021 SHALL drive prdata in RESP with reg_q[index] for writable registers and hw_status[index] for RO registers; prdata SHALL be 0 outside RESP and on error.
REQ-022 SHALL assert pslverr only in RESP and only for a decode error or a write to an RO register.
REQ-023 SHALL NOT change any register or wr_pulse on an errored transfer.
REQ-024 SHALL show a completed write on a read at the same address issued in the next transfer (no read-after-write hazard).

Reset
REQ-025 SHALL, while presetn=0, force FSM=IDLE, pready=0, pslverr=0, prdata=0, wr_pulse=0, and all registers=0.
REQ-026 SHALL abort any in-flight transfer on reset assertion mid-transfer, with no partial register update.
REQ-027 SHALL accept a new SETUP on the first pclk edge after presetn deasserts.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, SETUP, WAIT, RESP) and a function computing byte-strobe masks in a shared package apb_pkg.
REQ-029 SHALL contain one sub-module, apb_reg_bank, holding the storage array with byte-enable writes; the FSM and decode SHALL stay in the top level.

Verification
REQ-030 SHALL be checked with this scenario: write 6 to 0x7000_0000, then read it back -> prdata=6, pslverr=0, pready high for 1 cycle after WAIT_STATES=1 wait cycle.
REQ-031 SHALL be checked with this scenario: write 0x4C to 0x7000_0005 (misaligned) -> pslverr=1, all registers unchanged, no wr_pulse.
REQ-032 SHALL be checked with this scenario: write 0xAABBCCDD to reg 3, then write 0x11223344 with pstrb=4'b0101 -> read returns 0xAA22CC44.
REQ-033 SHALL be checked with this scenario: RO_MASK bit 2 set, hw_status[2]=0x55; write to 0x7000_0008 -> pslverr=1; read -> 0x55.
REQ-034 SHALL be checked with this scenario: read at 0x7000_0040 with NUM_REGS=16 -> pslverr=1, prdata=0.
REQ-035 SHALL be checked with this scenario: assert presetn=0 during WAIT of a write -> register unchanged, pready=0, next transfer completes normally.
